// File: rtl/ctrl_pipe_stages.sv
// ============================================================================
// Module      : ctrl_pipe_stages
// Description : ID/EX, EX/MEM and MEM/WB control-bundle pipeline with flag
//               register, flag forwarding, MEM-stage branch squash and
//               retired register-write counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_pipe_stages #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid_i,
    input  logic [3:0]       id_ex_i,
    input  logic [2:0]       id_mem_i,
    input  logic [1:0]       id_wb_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             alu_carry_i,
    input  logic             alu_zero_i,
    output logic [3:0]       ex_o,
    output logic [2:0]       mem_o,
    output logic [1:0]       wb_o,
    output logic             ex_valid_o,
    output logic             mem_valid_o,
    output logic             wb_valid_o,
    output logic             carry_o,
    output logic             zero_o,
    output logic             branch_taken_o,
    output logic [CNT_W-1:0] retired_o
);

    logic [3:0]       r_ex;
    logic             r_ex_valid;
    logic [2:0]       r_mem;
    logic             r_mem_valid;
    logic             r_exmem_zero;
    logic [1:0]       r_wb;
    logic             r_wb_valid;
    logic             r_carry;
    logic             r_zero;
    logic [CNT_W-1:0] r_retired;

    logic             w_branch_taken;
    logic             w_kill;
    logic             w_flag_we;
    logic             w_id_load;

    // Branch decision uses only registered state, so no path back from the ALU.
    assign w_branch_taken = r_mem_valid & r_mem[2] & r_exmem_zero;
    assign w_kill         = w_branch_taken | flush_i;
    assign w_flag_we      = r_ex_valid & r_ex[3] & ~w_kill;
    assign w_id_load      = id_valid_i & ~stall_i & ~w_kill;

    // ID/EX: bubble on kill, stall or empty decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex       <= 4'd0;
            r_ex_valid <= 1'b0;
        end else if (w_id_load) begin
            r_ex       <= id_ex_i;
            r_ex_valid <= 1'b1;
        end else begin
            r_ex       <= 4'd0;
            r_ex_valid <= 1'b0;
        end
    end

    // The mem and wb bundles ride alongside the ex bundle through ID/EX.
    logic [2:0] r_idex_mem;
    logic [1:0] r_idex_wb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idex_mem <= 3'd0;
            r_idex_wb  <= 2'd0;
        end else if (w_id_load) begin
            r_idex_mem <= id_mem_i;
            r_idex_wb  <= id_wb_i;
        end else begin
            r_idex_mem <= 3'd0;
            r_idex_wb  <= 2'd0;
        end
    end

    logic [1:0] r_exmem_wb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem        <= 3'd0;
            r_exmem_wb   <= 2'd0;
            r_mem_valid  <= 1'b0;
            r_exmem_zero <= 1'b0;
        end else if (w_kill) begin
            r_mem        <= 3'd0;
            r_exmem_wb   <= 2'd0;
            r_mem_valid  <= 1'b0;
            r_exmem_zero <= 1'b0;
        end else begin
            r_mem        <= r_idex_mem;
            r_exmem_wb   <= r_idex_wb;
            r_mem_valid  <= r_ex_valid;
            r_exmem_zero <= alu_zero_i;
        end
    end

    // MEM/WB never squashes: the branch itself must complete.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb       <= 2'd0;
            r_wb_valid <= 1'b0;
        end else begin
            r_wb       <= r_exmem_wb;
            r_wb_valid <= r_mem_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
        end else if (w_flag_we) begin
            r_carry <= alu_carry_i;
            r_zero  <= alu_zero_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retired <= '0;
        end else if (r_wb_valid && r_wb[1]) begin
            r_retired <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign ex_o           = r_ex;
    assign mem_o          = r_mem;
    assign wb_o           = r_wb;
    assign ex_valid_o     = r_ex_valid;
    assign mem_valid_o    = r_mem_valid;
    assign wb_valid_o     = r_wb_valid;
    assign carry_o        = w_flag_we ? alu_carry_i : r_carry;
    assign zero_o         = w_flag_we ? alu_zero_i  : r_zero;
    assign branch_taken_o = w_branch_taken;
    assign retired_o      = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_ctrl_pipe_stages.sv
// ============================================================================
// Module      : tb_ctrl_pipe_stages
// Description : Directed vector table plus hand sequences for ctrl_pipe_stages.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ctrl_pipe_stages;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid_i;
    logic [3:0]  id_ex_i;
    logic [2:0]  id_mem_i;
    logic [1:0]  id_wb_i;
    logic        stall_i;
    logic        flush_i;
    logic        alu_carry_i;
    logic        alu_zero_i;
    logic [3:0]  ex_o;
    logic [2:0]  mem_o;
    logic [1:0]  wb_o;
    logic        ex_valid_o;
    logic        mem_valid_o;
    logic        wb_valid_o;
    logic        carry_o;
    logic        zero_o;
    logic        branch_taken_o;
    logic [15:0] retired_o;

    always #5 clk = ~clk;

    ctrl_pipe_stages #(.CNT_W(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid_i     (id_valid_i),
        .id_ex_i        (id_ex_i),
        .id_mem_i       (id_mem_i),
        .id_wb_i        (id_wb_i),
        .stall_i        (stall_i),
        .flush_i        (flush_i),
        .alu_carry_i    (alu_carry_i),
        .alu_zero_i     (alu_zero_i),
        .ex_o           (ex_o),
        .mem_o          (mem_o),
        .wb_o           (wb_o),
        .ex_valid_o     (ex_valid_o),
        .mem_valid_o    (mem_valid_o),
        .wb_valid_o     (wb_valid_o),
        .carry_o        (carry_o),
        .zero_o         (zero_o),
        .branch_taken_o (branch_taken_o),
        .retired_o      (retired_o)
    );

    typedef struct {
        logic        v;
        logic [3:0]  ex;
        logic [2:0]  mem;
        logic [1:0]  wb;
        logic        st;
        logic        fl;
        logic        ac;
        logic        az;
        logic [3:0]  e_ex;
        logic [2:0]  e_mem;
        logic [1:0]  e_wb;
        logic [2:0]  e_val;
        logic        e_c;
        logic        e_z;
        logic        e_bt;
        logic [15:0] e_ret;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[22];

    // Observed outputs packed {ex, mem, wb, valids(ex,mem,wb), carry, zero, bt, retired}.
    wire [30:0] w_act = {ex_o, mem_o, wb_o, ex_valid_o, mem_valid_o, wb_valid_o,
                         carry_o, zero_o, branch_taken_o, retired_o};

    function automatic vec_t mk(input logic v, input logic [3:0] ex, input logic [2:0] mem,
                                input logic [1:0] wb, input logic st, input logic fl,
                                input logic ac, input logic az, input logic [3:0] e_ex,
                                input logic [2:0] e_mem, input logic [1:0] e_wb,
                                input logic [2:0] e_val, input logic e_c, input logic e_z,
                                input logic e_bt, input logic [15:0] e_ret);
        vec_t r;
        r.v = v; r.ex = ex; r.mem = mem; r.wb = wb; r.st = st; r.fl = fl; r.ac = ac; r.az = az;
        r.e_ex = e_ex; r.e_mem = e_mem; r.e_wb = e_wb; r.e_val = e_val;
        r.e_c = e_c; r.e_z = e_z; r.e_bt = e_bt; r.e_ret = e_ret;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] ex, input logic [2:0] mem,
                         input logic [1:0] wb, input logic st, input logic fl,
                         input logic ac, input logic az);
        id_valid_i = v; id_ex_i = ex; id_mem_i = mem; id_wb_i = wb;
        stall_i = st; flush_i = fl; alu_carry_i = ac; alu_zero_i = az;
    endtask

    initial begin
        // Rows: inputs for one cycle, outputs expected during that same cycle.
        //            v  ex  mem wb st fl ac az | ex mem wb val c z bt ret
        vecs[0]  = mk(1, 9,  1, 3, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 0,  0, 0, 0, 0, 1, 0,   9, 0, 0, 4, 1, 0, 0, 0);
        vecs[2]  = mk(0, 0,  0, 0, 0, 0, 0, 1,   0, 1, 0, 2, 1, 0, 0, 0);
        vecs[3]  = mk(0, 0,  0, 0, 0, 0, 0, 0,   0, 0, 3, 1, 1, 0, 0, 0);
        vecs[4]  = mk(0, 0,  0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0, 1);
        // taken branch, flag instruction behind it, valid decode instruction
        vecs[5]  = mk(1, 0,  4, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0, 1);
        vecs[6]  = mk(1, 8,  0, 2, 0, 0, 0, 1,   0, 0, 0, 4, 1, 0, 0, 1);
        vecs[7]  = mk(1, 1,  2, 2, 0, 0, 0, 1,   8, 4, 0, 6, 1, 0, 1, 1);
        vecs[8]  = mk(0, 0,  0, 0, 0, 0, 1, 1,   0, 0, 0, 1, 1, 0, 0, 1);
        // untaken branch
        vecs[9]  = mk(1, 0,  4, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0, 1);
        vecs[10] = mk(1, 2,  0, 2, 0, 0, 0, 0,   0, 0, 0, 4, 1, 0, 0, 1);
        vecs[11] = mk(1, 3,  0, 2, 0, 0, 1, 1,   2, 4, 0, 6, 1, 0, 0, 1);
        vecs[12] = mk(0, 0,  0, 0, 0, 0, 0, 0,   3, 0, 0, 7, 1, 0, 0, 1);
        vecs[13] = mk(0, 0,  0, 0, 0, 0, 0, 0,   0, 0, 2, 3, 1, 0, 0, 1);
        vecs[14] = mk(0, 0,  0, 0, 0, 0, 0, 0,   0, 0, 2, 1, 1, 0, 0, 2);
        vecs[15] = mk(0, 0,  0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0, 3);
        // two stall cycles, then stall together with flush
        vecs[16] = mk(1, 1,  1, 2, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0, 3);
        vecs[17] = mk(1, 10, 0, 2, 1, 0, 0, 0,   1, 0, 0, 4, 1, 0, 0, 3);
        vecs[18] = mk(1, 10, 0, 2, 1, 0, 0, 0,   0, 1, 0, 2, 1, 0, 0, 3);
        vecs[19] = mk(1, 10, 0, 2, 0, 0, 0, 0,   0, 0, 2, 1, 1, 0, 0, 3);
        vecs[20] = mk(1, 3,  0, 2, 1, 1, 0, 1,  10, 0, 0, 4, 1, 0, 0, 4);
        vecs[21] = mk(0, 0,  0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 1, 0, 0, 4);

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {1'b0, w_act}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            drive(vecs[i].v, vecs[i].ex, vecs[i].mem, vecs[i].wb,
                  vecs[i].st, vecs[i].fl, vecs[i].ac, vecs[i].az);
            #1;
            check($sformatf("vec%0d", i), {1'b0, w_act},
                  {1'b0, vecs[i].e_ex, vecs[i].e_mem, vecs[i].e_wb, vecs[i].e_val,
                   vecs[i].e_c, vecs[i].e_z, vecs[i].e_bt, vecs[i].e_ret});
            @(posedge clk);
            #1;
        end

        // Counter wrap: 4 retired so far, 65531 more reach 16'hFFFF.
        drive(1, 0, 0, 2, 0, 0, 0, 0);
        repeat (65531) @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) @(posedge clk);
        #1;
        check("retired_max", {16'd0, retired_o}, 32'h0000_FFFF);
        drive(1, 0, 0, 2, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) @(posedge clk);
        #1;
        check("retired_wrap", {16'd0, retired_o}, 32'd0);
        check("drained_idle", {1'b0, w_act}, {1'b0, 15'b0000_000_00_000_1_0_0, 16'd0});

        // Mid-stream asynchronous reset.
        drive(1, 9, 1, 3, 0, 0, 1, 1);
        repeat (5) @(posedge clk);
        #2;
        check("pre_reset_retired", {16'd0, retired_o}, 32'd2);
        check("pre_reset_carry", {31'd0, carry_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset", {1'b0, w_act}, 32'd0);
        @(posedge clk);
        #1;
        check("reset_held", {1'b0, w_act}, 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_release", {1'b0, w_act}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ctrl_pipe_stages.md
# ctrl_pipe_stages

Carries the decoded control bundles (ex[3:0], mem[2:0], wb[1:0]) from the decode-stage main controller through the ID/EX, EX/MEM and MEM/WB pipeline registers. It owns the architectural carry/zero flag register and forwards flag values back to the main controller in decode. It also resolves taken branches in MEM and squashes younger instructions, and it counts retired register writes. It is the consuming end of the main controller's ex/mem/wb interface and the producing end of its carry/zero inputs.

## Interface
- CNT_W, 16, width of the retired-write counter
- clk  input  1  pipeline clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- id_valid_i  input  1  decode stage holds a real instruction
- id_ex_i  input  4  ex bundle from main controller: [1:0] ALU function, [2] ALU B-source immediate, [3] flag update
- id_mem_i  input  3  mem bundle: [0] mem read, [1] mem write, [2] branch-on-zero
- id_wb_i  input  2  wb bundle: [0] mem-to-reg select, [1] register write (already condition-gated)
- stall_i  input  1  hazard unit holds decode; insert bubble into ID/EX
- flush_i  input  1  external squash (exception), same effect as taken branch
- alu_carry_i, alu_zero_i  input  1 each  EX-stage ALU results
- ex_o / mem_o / wb_o  output  4 / 3 / 2  bundles held in ID/EX, EX/MEM, MEM/WB
- ex_valid_o, mem_valid_o, wb_valid_o  output  1 each  stage valid bits
- carry_o, zero_o  output  1 each  forwarded flags to main controller
- branch_taken_o  output  1  squash request to fetch (combinational)
- retired_o  output  CNT_W  count of retired register writes

## Operation
- kill = branch_taken_o | flush_i.
- branch_taken_o = mem_valid_o & mem_o[2] & exmem_zero_q. exmem_zero_q is alu_zero_i captured with the EX/MEM register. It is registered-only, so there is no combinational loop.
- ID/EX update, in priority order:
  - If kill or stall_i or !id_valid_i: load bubble (valid 0, all bundle bits 0).
  - Otherwise: load id_* and set valid 1.
- EX/MEM update:
  - If kill: load bubble.
  - Otherwise: copy ID/EX, and capture alu_zero_i into exmem_zero_q.
- MEM/WB update: always copies EX/MEM. The branch instruction itself completes; only younger instructions are killed.
- flag_we = ex_valid_o & ex_o[3] & !kill. When flag_we is set, carry_q/zero_q ← alu_carry_i/alu_zero_i at the edge.
- Forwarding:
  - carry_o = flag_we ? alu_carry_i : carry_q.
  - zero_o = flag_we ? alu_zero_i : zero_q.
  - A squashed EX instruction never affects the flags, either forwarded or registered.
- retired_o increments by 1 on each edge where wb_valid_o & wb_o[1]. It wraps from 2^CNT_W−1 to 0.
- Bubbles carry all-zero bundles, so downstream write/read enables are inactive without extra gating.

## Timing
- Reset (async, rst_n=0): all bundles 0, all valids 0, carry_q=zero_q=0, exmem_zero_q=0, retired_o=0, branch_taken_o=0.
  - Outputs take these values immediately, independent of clk.
  - Release is synchronous to the next rising edge.
- Latency: an instruction accepted at edge n (id_valid_i=1, stall_i=0, kill=0) appears on ex_o after edge n, mem_o after edge n+1, and wb_o after edge n+2.
- Flags:
  - A flag-updating instruction in EX during cycle c is visible on carry_o/zero_o combinationally in cycle c.
  - It is registered at the end of cycle c.
  - A dependent instruction in decode during cycle c sees the new value with no stall.
- Branch:
  - branch_taken_o is high for exactly the cycle the branch sits in EX/MEM.
  - At that edge, the EX instruction and the decode instruction are both discarded.
  - The branch moves to MEM/WB.
- Simultaneous stall_i and kill: kill wins; the result is identical to kill alone.
- Back-to-back taken branches cannot occur: the second branch is always squashed by the first.
- Reset asserted mid-pipeline discards all in-flight instructions and does not increment retired_o.

## Test plan
- Reset then a single instruction with id_ex_i=4'h9, id_mem_i=3'b001, id_wb_i=2'b11 at edge 1 → ex_o=9 after edge 1, mem_o=1 after edge 2, wb_o=3 after edge 3, retired_o=1 after edge 4; valids track the instruction.
- Flag instruction (ex[3]=1) in EX with alu_carry_i=1, alu_zero_i=0 → carry_o=1 in the same cycle, carry_q=1 after the edge; the next cycle has no flag update and carry_o stays 1.
- Branch (mem[2]=1) with alu_zero_i=1 in EX, a flag-updating instruction behind it, and a valid instruction in decode:
  - branch_taken_o=1 for one cycle.
  - ex_valid_o and mem_valid_o are both 0 after the edge.
  - Flags are unchanged and carry_o does not show alu_carry_i in the kill cycle.
  - wb_valid_o=1 for the branch.
- Branch with zero=0 → branch_taken_o stays 0 and no bubbles are inserted.
- stall_i=1 for 2 cycles with a stream of instructions → two bubbles with all-zero bundles at ex_o; older instructions keep advancing; stall_i together with flush_i behaves as flush only.
- Preload retired_o to 16'hFFFF via 65535 retires (or force), then one register-write retire → wraps to 0. Assert rst_n=0 mid-stream → all outputs zero asynchronously.
